// File: rtl/mm_result_drain.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// Module: MmResultDrain (mm_result_drain)
//
// Purpose
//   Collects finished output tiles from the systolic matmul stage, buffers
//   them in a small tile FIFO and streams each tile out one word per
//   valid/ready beat. Lane 0 of a tile goes out first. m_last marks the
//   final lane. The matmul stage cannot be back-pressured, so this block
//   raises stall_req early enough that upstream can stop enable_matmul
//   before the FIFO overflows.
//
// Ports
//   clk        in   clock, everything updates on the rising edge
//   rst        in   synchronous active-high reset (also zeroes tiles_out)
//   clear      in   synchronous flush: empties FIFO, lane index and overflow
//   in_valid   in   one-cycle pulse, in_data carries a complete tile
//   in_data    in   NUM_LANES*DATA_WIDTH, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   stall_req  out  FIFO holds DEPTH-1 or more tiles, upstream must hold off
//   m_valid    out  an output word is available
//   m_ready    in   consumer takes the current word this cycle
//   m_data     out  head tile, current lane
//   m_last     out  current word is the last lane of the head tile
//   overflow   out  sticky flag, a tile arrived while the FIFO was full
//   tiles_out  out  number of tiles fully drained, wraps naturally
// ---------------------------------------------------------------------------
module mm_result_drain #(
   parameter int NUM_LANES  = 4,
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            clear,
   input  logic                            in_valid,
   input  logic [NUM_LANES*DATA_WIDTH-1:0] in_data,
   output logic                            stall_req,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic [DATA_WIDTH-1:0]           m_data,
   output logic                            m_last,
   output logic                            overflow,
   output logic [CNT_WIDTH-1:0]            tiles_out
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]  STALL_CNT = CNT_W'(DEPTH - 1);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

   // A tile viewed as an array of lanes; the packed layout places lane k at
   // [k*DATA_WIDTH +: DATA_WIDTH], exactly like in_data.
   typedef logic [NUM_LANES-1:0][DATA_WIDTH-1:0] tile_t;

   tile_t               mem_q [DEPTH];

   logic [PTR_W-1:0]     wr_ptr_q,   wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q,   rd_ptr_d;
   logic [CNT_W-1:0]     count_q,    count_d;
   logic [LANE_W-1:0]    lane_q,     lane_d;
   logic                 overflow_q, overflow_d;
   logic [CNT_WIDTH-1:0] tiles_q,    tiles_d;

   logic notEmpty;
   logic isFull;
   logic onLastLane;
   logic beat;
   logic pop;
   logic push;
   logic drop;

   // Handshake decode. A pop is only the beat that retires the last lane of
   // the head tile; freeing that slot lets a tile arriving in the same cycle
   // into a full FIFO instead of being dropped.
   always_comb begin
      notEmpty   = (count_q != '0);
      isFull     = (count_q == FULL_CNT);
      onLastLane = (lane_q == LAST_LANE);
      beat       = notEmpty && m_ready;
      pop        = beat && onLastLane;
      push       = in_valid && (!isFull || pop);
      drop       = in_valid && isFull && !pop;
   end

   // Next-state for pointers, occupancy, lane position and status. Pointers
   // wrap for free because DEPTH is a power of two. A simultaneous push and
   // pop leaves the occupancy unchanged.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      lane_d     = lane_q;
      overflow_d = overflow_q;
      tiles_d    = tiles_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end

      if (beat) begin
         if (onLastLane) begin
            lane_d = '0;
         end else begin
            lane_d = lane_q + LANE_W'(1);
         end
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
         tiles_d  = tiles_q + CNT_WIDTH'(1);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      if (drop) begin
         overflow_d = 1'b1;
      end
   end

   // Control state register. Reset and clear both flush the FIFO and win
   // over any traffic in that cycle; only reset forgets the drained-tile
   // count so software can keep a running total across flushes.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         lane_q     <= '0;
         overflow_q <= 1'b0;
         tiles_q    <= '0;
      end else if (clear) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         lane_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         lane_q     <= lane_d;
         overflow_q <= overflow_d;
         tiles_q    <= tiles_d;
      end
   end

   // Tile storage has no reset; entries are only ever read once the
   // occupancy says they were written. Writes are suppressed in a
   // reset/clear cycle so a flushed push cannot leave a stale tile behind
   // the pointers.
   always_ff @(posedge clk) begin
      if (push && !rst && !clear) begin
         mem_q[wr_ptr_q] <= tile_t'(in_data);
      end
   end

   // Outputs come straight from registered state, so m_data/m_last hold
   // steady while the consumer stalls and m_ready never reaches m_valid.
   always_comb begin
      m_valid   = notEmpty;
      m_data    = mem_q[rd_ptr_q][lane_q];
      m_last    = notEmpty && onLastLane;
      stall_req = (count_q >= STALL_CNT);
      overflow  = overflow_q;
      tiles_out = tiles_q;
   end

endmodule

// File: tb/tb_mm_result_drain.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// Testbench for mm_result_drain.
//
// A queue-of-tiles reference model tracks what the drain must present on
// every cycle; a compare process checks all outputs against it on each
// falling edge. Directed sequences add literal expectations at key points.
// A second instance with a 4-bit tiles_out counter shares every input so
// that counter wrap-around is reached within a short run.
// ---------------------------------------------------------------------------
module tb_mm_result_drain;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic        in_valid;
   logic [63:0] in_data;
   logic        m_ready;

   logic        stall_req, m_valid, m_last, overflow;
   logic [15:0] m_data;
   logic [15:0] tiles_out;

   logic        sStall, sValid, sLast, sOverflow;
   logic [15:0] sData;
   logic [3:0]  sTiles;

   int nChecks = 0;
   int nPassed = 0;

   // Reference model state
   logic [63:0] mQ[$];
   int          mLane  = 0;
   logic        mOvf   = 1'b0;
   logic [15:0] mTiles = 16'd0;

   always #5 clk = ~clk;

   mm_result_drain dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .stall_req (stall_req),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_last    (m_last),
      .overflow  (overflow),
      .tiles_out (tiles_out)
   );

   mm_result_drain #(.CNT_WIDTH(4)) dutSmall (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .stall_req (sStall),
      .m_valid   (sValid),
      .m_ready   (m_ready),
      .m_data    (sData),
      .m_last    (sLast),
      .overflow  (sOverflow),
      .tiles_out (sTiles)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      nChecks++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end else begin
         nPassed++;
      end
   endtask

   // Drive one cycle of inputs, then return on the next falling edge so the
   // caller sees the state produced by the rising edge in between.
   task automatic applyStimulus(input logic v, input logic [63:0] d,
                                input logic rdy, input logic clr);
      in_valid = v;
      in_data  = d;
      m_ready  = rdy;
      clear    = clr;
      @(negedge clk);
   endtask

   function automatic logic [63:0] makeTile(input logic [15:0] l0, input logic [15:0] l1,
                                            input logic [15:0] l2, input logic [15:0] l3);
      return {l3, l2, l1, l0};
   endfunction

   function automatic logic [63:0] seqTile(input logic [15:0] base);
      return makeTile(base, base + 16'd1, base + 16'd2, base + 16'd3);
   endfunction

   // Reference model: FIFO of whole tiles, a lane cursor into the head tile,
   // a sticky drop flag and a drained-tile counter.
   always @(posedge clk) begin
      int sizeBefore;
      bit doBeat;
      bit doPop;
      if (rst) begin
         mQ.delete();
         mLane  = 0;
         mOvf   = 1'b0;
         mTiles = 16'd0;
      end else if (clear) begin
         mQ.delete();
         mLane = 0;
         mOvf  = 1'b0;
      end else begin
         sizeBefore = mQ.size();
         doBeat     = (sizeBefore != 0) && m_ready;
         doPop      = doBeat && (mLane == 3);
         if (doBeat) begin
            if (doPop) begin
               void'(mQ.pop_front());
               mLane  = 0;
               mTiles = mTiles + 16'd1;
            end else begin
               mLane = mLane + 1;
            end
         end
         if (in_valid) begin
            if (sizeBefore < 4 || doPop) mQ.push_back(in_data);
            else mOvf = 1'b1;
         end
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      logic        expValid;
      logic [15:0] expData;
      expValid = (mQ.size() != 0);
      expData  = expValid ? mQ[0][mLane*16 +: 16] : 16'd0;
      checkOutput("m_valid",   m_valid,   expValid);
      checkOutput("m_last",    m_last,    expValid && (mLane == 3));
      checkOutput("stall_req", stall_req, mQ.size() >= 3);
      checkOutput("overflow",  overflow,  mOvf);
      checkOutput("tiles_out", tiles_out, mTiles);
      if (expValid) checkOutput("m_data", m_data, expData);
      checkOutput("small_m_valid",   sValid,    expValid);
      checkOutput("small_m_last",    sLast,     expValid && (mLane == 3));
      checkOutput("small_stall_req", sStall,    mQ.size() >= 3);
      checkOutput("small_overflow",  sOverflow, mOvf);
      checkOutput("small_tiles_out", sTiles,    mTiles[3:0]);
      if (expValid) checkOutput("small_m_data", sData, expData);
   end

   // Watchdog so a broken design can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] run did not complete");
   end

   initial begin
      rst      = 1'b1;
      clear    = 1'b0;
      in_valid = 1'b0;
      in_data  = 64'd0;
      m_ready  = 1'b0;

      // Test 1: reset for two cycles, then one tile streamed straight through
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_m_valid",   m_valid,   1'b0);
      checkOutput("rst_m_last",    m_last,    1'b0);
      checkOutput("rst_stall_req", stall_req, 1'b0);
      checkOutput("rst_overflow",  overflow,  1'b0);
      checkOutput("rst_tiles_out", tiles_out, 16'd0);
      rst = 1'b0;

      applyStimulus(1'b1, makeTile(16'd1, 16'd2, 16'd3, 16'd4), 1'b1, 1'b0);
      checkOutput("t1_word0", m_data, 16'd1);
      checkOutput("t1_last0", m_last, 1'b0);
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
      checkOutput("t1_word1", m_data, 16'd2);
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
      checkOutput("t1_word2", m_data, 16'd3);
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
      checkOutput("t1_word3", m_data, 16'd4);
      checkOutput("t1_last3", m_last, 1'b1);
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
      checkOutput("t1_empty", m_valid, 1'b0);
      checkOutput("t1_tiles", tiles_out, 16'd1);

      // Test 2: fill with consumer stalled, overflow on the fifth tile, drain
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, seqTile(16'h2000 + 16'(i * 16)), 1'b0, 1'b0);
         if (i == 1) checkOutput("t2_stall_after2", stall_req, 1'b0);
         if (i == 2) checkOutput("t2_stall_after3", stall_req, 1'b1);
      end
      checkOutput("t2_overflow", overflow, 1'b1);
      checkOutput("t2_head", m_data, 16'h2000);
      for (int b = 0; b < 16; b++) begin
         applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
         if (b == 0)  checkOutput("t2_second_word", m_data, 16'h2001);
         if (b == 14) checkOutput("t2_final_word", m_data, 16'h2033);
      end
      checkOutput("t2_empty", m_valid, 1'b0);
      checkOutput("t2_tiles", tiles_out, 16'd5);

      // Test 3: full FIFO, new tile lands on the popping beat
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b1);
      checkOutput("t3_clear_ovf", overflow, 1'b0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, seqTile(16'h3000 + 16'(i * 16)), 1'b0, 1'b0);
      end
      for (int b = 0; b < 3; b++) applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
      checkOutput("t3_lane3_word", m_data, 16'h3003);
      checkOutput("t3_lane3_last", m_last, 1'b1);
      applyStimulus(1'b1, seqTile(16'h3040), 1'b1, 1'b0);
      checkOutput("t3_no_overflow", overflow, 1'b0);
      checkOutput("t3_still_stall", stall_req, 1'b1);
      checkOutput("t3_next_head", m_data, 16'h3010);
      for (int b = 0; b < 15; b++) applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
      checkOutput("t3_accepted_tile", m_data, 16'h3043);
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
      checkOutput("t3_empty", m_valid, 1'b0);
      checkOutput("t3_tiles", tiles_out, 16'd10);

      // Test 4: consumer toggles ready mid-tile
      applyStimulus(1'b1, seqTile(16'h4001), 1'b0, 1'b0);
      checkOutput("t4_w0", m_data, 16'h4001);
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
      checkOutput("t4_w1", m_data, 16'h4002);
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
      checkOutput("t4_w1_hold", m_data, 16'h4002);
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
      checkOutput("t4_w2", m_data, 16'h4003);
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
      checkOutput("t4_w2_hold", m_data, 16'h4003);
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
      checkOutput("t4_w3", m_data, 16'h4004);
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
      checkOutput("t4_w3_hold_last", m_last, 1'b1);
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
      checkOutput("t4_empty", m_valid, 1'b0);
      checkOutput("t4_tiles", tiles_out, 16'd11);

      // Test 5: clear in the middle of a tile with two tiles queued
      applyStimulus(1'b1, seqTile(16'h5000), 1'b0, 1'b0);
      applyStimulus(1'b1, seqTile(16'h5010), 1'b0, 1'b0);
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
      checkOutput("t5_lane2", m_data, 16'h5002);
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b1);
      checkOutput("t5_clear_valid", m_valid, 1'b0);
      checkOutput("t5_clear_ovf", overflow, 1'b0);
      checkOutput("t5_clear_tiles", tiles_out, 16'd11);
      applyStimulus(1'b1, seqTile(16'h5020), 1'b1, 1'b0);
      checkOutput("t5_restart_lane0", m_data, 16'h5020);
      for (int b = 0; b < 4; b++) applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
      checkOutput("t5_tiles", tiles_out, 16'd12);

      // Test 6: drained-tile counter wraps (4-bit instance wraps at 16)
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, seqTile(16'h6000 + 16'(i * 16)), 1'b1, 1'b0);
         for (int b = 0; b < 4; b++) applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
      end
      checkOutput("t6_tiles16", tiles_out, 16'd16);
      checkOutput("t6_small_wrap", sTiles, 4'd0);
      applyStimulus(1'b1, seqTile(16'h6040), 1'b1, 1'b0);
      for (int b = 0; b < 4; b++) applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
      checkOutput("t6_tiles17", tiles_out, 16'd17);
      checkOutput("t6_small_after_wrap", sTiles, 4'd1);

      $display("%0d/%0d checks passed", nPassed, nChecks);
      $finish;
   end

endmodule
